mem_exec_unit: RTL and testbench

//  Memory execute stage directly downstream of the load/store queue. Accepts one popped ld/st entry

---
 rtl/mem_exec_unit.sv | 98 +++++++++
 tb/tb_mem_exec_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_exec_unit.sv
// mem_exec_unit: single-op load/store execute stage with dmem handshake and CDB broadcast
module mem_exec_unit #(
  parameter int PHYS_IDX_W = 6,
  parameter int ROB_IDX_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [6:0]            issue_opcode,
  input  logic [2:0]            issue_funct3,
  input  logic [31:0]           issue_rs1_data,
  input  logic [31:0]           issue_rs2_data,
  input  logic [31:0]           issue_imm,
  input  logic [PHYS_IDX_W-1:0] issue_phys_rd,
  input  logic [ROB_IDX_W-1:0]  issue_rob_idx,
  output logic [31:0]           dmem_addr,
  output logic [3:0]            dmem_rmask,
  output logic [3:0]            dmem_wmask,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  cdb_valid,
  output logic [PHYS_IDX_W-1:0] cdb_phys_rd,
  output logic [ROB_IDX_W-1:0]  cdb_rob_idx,
  output logic [31:0]           cdb_data,
  output logic                  cdb_is_store,
  output logic                  cdb_misalign
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] ea, ea_q, wdata_q, data_q, lane, ext;
  logic [2:0] f3_q;
  logic st_q, mis_q, bad_f3, mis, accept;
  logic [3:0] mask;
  logic [PHYS_IDX_W-1:0] prd_q;
  logic [ROB_IDX_W-1:0] rob_q;
  assign ea = issue_rs1_data + issue_imm;
  assign bad_f3 = issue_funct3 == 3'b011 || issue_funct3 == 3'b110 || issue_funct3 == 3'b111;
  assign mis = bad_f3 || (issue_funct3[1:0] == 2'b01 && ea[0]) || (issue_funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
  assign accept = state == IDLE && issue_valid && !flush;
  assign mask = f3_q[1:0] == 2'b00 ? 4'b0001 << ea_q[1:0] :
                f3_q[1:0] == 2'b01 ? 4'b0011 << ea_q[1:0] : 4'b1111;
  assign lane = dmem_rdata >> {ea_q[1:0], 3'b000};
  assign ext = f3_q == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
               f3_q == 3'b001 ? {{16{lane[15]}}, lane[15:0]} :
               f3_q == 3'b100 ? {24'd0, lane[7:0]} :
               f3_q == 3'b101 ? {16'd0, lane[15:0]} : dmem_rdata;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next-state: flush squashes the op; a response already in flight is drained first
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (mis ? DONE : REQ) : IDLE;
      REQ:     state_nxt = flush ? IDLE : WAIT;
      WAIT:    state_nxt = dmem_resp ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
      DRAIN:   state_nxt = dmem_resp ? IDLE : DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // op fields latched at accept; load result captured on the memory response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ea_q <= '0;
      wdata_q <= '0;
      data_q <= '0;
      f3_q <= '0;
      st_q <= 1'b0;
      mis_q <= 1'b0;
      prd_q <= '0;
      rob_q <= '0;
    end else if (accept) begin
      ea_q <= ea;
      wdata_q <= issue_rs2_data << {ea[1:0], 3'b000};
      data_q <= '0;
      f3_q <= issue_funct3;
      st_q <= issue_opcode == 7'b0100011;
      mis_q <= mis;
      prd_q <= issue_phys_rd;
      rob_q <= issue_rob_idx;
    end else if (state == WAIT && dmem_resp && !flush && !st_q) data_q <= ext;
  assign issue_ready = state == IDLE;
  assign dmem_addr = state == REQ || state == WAIT ? {ea_q[31:2], 2'b00} : '0;
  assign dmem_wdata = (state == REQ || state == WAIT) && st_q ? wdata_q : '0;
  assign dmem_rmask = state == REQ && !flush && !st_q ? mask : 4'b0000;
  assign dmem_wmask = state == REQ && !flush && st_q ? mask : 4'b0000;
  assign cdb_valid = state == DONE && !flush;
  assign cdb_phys_rd = cdb_valid && !st_q ? prd_q : '0;
  assign cdb_rob_idx = cdb_valid ? rob_q : '0;
  assign cdb_data = cdb_valid ? data_q : '0;
  assign cdb_is_store = cdb_valid && st_q;
  assign cdb_misalign = cdb_valid && mis_q;
endmodule

// File: tb/tb_mem_exec_unit.sv
// tb_mem_exec_unit: directed checks of address/mask formation, load extension, flush and reset
module tb_mem_exec_unit;
  logic clk = 0, rst = 1, flush = 0, issue_valid = 0, issue_ready, dmem_resp = 0;
  logic [6:0] issue_opcode = 0;
  logic [2:0] issue_funct3 = 0;
  logic [31:0] issue_rs1_data = 0, issue_rs2_data = 0, issue_imm = 0, dmem_rdata = 0;
  logic [31:0] dmem_addr, dmem_wdata, cdb_data;
  logic [5:0] issue_phys_rd = 0, cdb_phys_rd;
  logic [4:0] issue_rob_idx = 0, cdb_rob_idx;
  logic [3:0] dmem_rmask, dmem_wmask;
  logic cdb_valid, cdb_is_store, cdb_misalign;
  int total = 0, bad = 0;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
  mem_exec_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_funct3(issue_funct3), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .issue_imm(issue_imm), .issue_phys_rd(issue_phys_rd),
    .issue_rob_idx(issue_rob_idx), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .cdb_valid(cdb_valid), .cdb_phys_rd(cdb_phys_rd), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
    .cdb_is_store(cdb_is_store), .cdb_misalign(cdb_misalign));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rob);
    chk("ready_at_issue", issue_ready, 1);
    issue_valid = 1; issue_opcode = opc; issue_funct3 = f3; issue_rs1_data = rs1;
    issue_rs2_data = rs2; issue_imm = imm; issue_phys_rd = {1'b1, rob}; issue_rob_idx = rob;
    step();
    issue_valid = 0;
  endtask
  task automatic ld(input string t, input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm,
                    input logic [31:0] rdata, input logic [31:0] addr, input logic [3:0] m,
                    input logic [31:0] d, input logic [4:0] rob);
    issue(LD, f3, rs1, 32'h0, imm, rob);
    chk({t, "_addr"}, dmem_addr, addr);
    chk({t, "_rmask"}, {28'd0, dmem_rmask}, {28'd0, m});
    chk({t, "_wmask"}, {28'd0, dmem_wmask}, 0);
    chk({t, "_req_nocdb"}, cdb_valid, 0);
    step();
    dmem_resp = 1; dmem_rdata = rdata;
    chk({t, "_wait_addr"}, dmem_addr, addr);
    chk({t, "_wait_rmask"}, {28'd0, dmem_rmask}, 0);
    step();
    dmem_resp = 0;
    chk({t, "_cdb_valid"}, cdb_valid, 1);
    chk({t, "_cdb_data"}, cdb_data, d);
    chk({t, "_cdb_rob"}, {27'd0, cdb_rob_idx}, {27'd0, rob});
    chk({t, "_cdb_prd"}, {26'd0, cdb_phys_rd}, {26'd0, 1'b1, rob});
    chk({t, "_cdb_flags"}, {30'd0, cdb_is_store, cdb_misalign}, 0);
    step();
    chk({t, "_cdb_pulse"}, cdb_valid, 0);
  endtask
  initial begin
    step(); step();
    chk("rst_ready", issue_ready, 1);
    chk("rst_outs", {dmem_rmask, dmem_wmask, cdb_valid, cdb_misalign}, 0);
    chk("rst_addr", dmem_addr, 0);
    rst = 0;
    step();
    ld("lw", 3'b010, 32'h1000, 32'h4, 32'hDEADBEEF, 32'h1004, 4'b1111, 32'hDEADBEEF, 5'd1);
    ld("lb", 3'b000, 32'h2000, 32'h3, 32'h80123456, 32'h2000, 4'b1000, 32'hFFFFFF80, 5'd2);
    ld("lbu", 3'b100, 32'h2000, 32'h3, 32'h80123456, 32'h2000, 4'b1000, 32'h00000080, 5'd3);
    // store halfword upper lane
    issue(ST, 3'b001, 32'h3000, 32'h1234ABCD, 32'h2, 5'd4);
    chk("sh_wmask", {28'd0, dmem_wmask}, 32'hC);
    chk("sh_rmask", {28'd0, dmem_rmask}, 0);
    chk("sh_wdata", dmem_wdata, 32'hABCD0000);
    chk("sh_addr", dmem_addr, 32'h3000);
    step();
    dmem_resp = 1;
    dmem_rdata = 32'hFFFFFFFF;
    step();
    dmem_resp = 0;
    chk("sh_cdb", {cdb_valid, cdb_is_store, cdb_misalign}, 3'b110);
    chk("sh_cdb_data", cdb_data, 0);
    chk("sh_cdb_prd", {26'd0, cdb_phys_rd}, 0);
    step();
    // misaligned word: completes at c1 without touching memory
    issue(LD, 3'b010, 32'h4000, 32'h0, 32'h1, 5'd5);
    chk("mis_cdb", {cdb_valid, cdb_misalign, cdb_is_store}, 3'b110);
    chk("mis_masks", {28'd0, dmem_rmask | dmem_wmask}, 0);
    chk("mis_rob", {27'd0, cdb_rob_idx}, 5);
    step();
    chk("mis_pulse", cdb_valid, 0);
    chk("mis_ready", issue_ready, 1);
    // illegal funct3
    issue(LD, 3'b011, 32'h4000, 32'h0, 32'h0, 5'd6);
    chk("badf3_cdb", {cdb_valid, cdb_misalign}, 2'b11);
    step();
    // flush in IDLE drops the op
    flush = 1;
    issue(LD, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd7);
    flush = 0;
    chk("flush_idle_ready", issue_ready, 1);
    chk("flush_idle_rmask", {28'd0, dmem_rmask}, 0);
    // flush in REQ suppresses the request
    issue(LD, 3'b010, 32'h5000, 32'h0, 32'h0, 5'd8);
    chk("req_pre_rmask", {28'd0, dmem_rmask}, 32'hF);
    flush = 1;
    #1;
    chk("flush_req_rmask", {28'd0, dmem_rmask}, 0);
    step();
    flush = 0;
    chk("flush_req_idle", issue_ready, 1);
    // flush in WAIT, late response drains
    issue(LD, 3'b010, 32'h6000, 32'h0, 32'h0, 5'd9);
    step();
    flush = 1;
    step();
    flush = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin dmem_resp = 1; dmem_rdata = 32'h11111111; end
      chk("drain_ready", issue_ready, 0);
      chk("drain_nocdb", cdb_valid, 0);
      step();
    end
    dmem_resp = 0;
    chk("drain_done_ready", issue_ready, 1);
    chk("drain_done_nocdb", cdb_valid, 0);
    // async reset mid-WAIT
    issue(LD, 3'b010, 32'h7000, 32'h0, 32'h0, 5'd10);
    step();
    chk("wait_addr", dmem_addr, 32'h7000);
    #2 rst = 1;
    #1;
    chk("arst_addr", dmem_addr, 0);
    chk("arst_ready", issue_ready, 1);
    chk("arst_cdb", cdb_valid, 0);
    step();
    rst = 0;
    step();
    ld("b2b_lw", 3'b010, 32'h8000, 32'h8, 32'hCAFEF00D, 32'h8008, 4'b1111, 32'hCAFEF00D, 5'd11);
    ld("b2b_lh", 3'b001, 32'h5000, 32'h2, 32'h80011234, 32'h5000, 4'b1100, 32'hFFFF8001, 5'd12);
    ld("b2b_lhu", 3'b101, 32'h5000, 32'h2, 32'h80011234, 32'h5000, 4'b1100, 32'h00008001, 5'd13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
